nibble_serial_subtractor: RTL and testbench
===========================================

// Module: nibble_serial_subtractor
// PURPOSE
//  Multi-cycle WIDTH-bit subtract/add unit built on a single 4-bit ripple slice
//  reused over WIDTH/4 cycles, LSB nibble first, borrow/carry held in a flop.
//  Area-lean counterpart to the single-cycle 4-bit adder: computes a-b (or a+b)
//  for the branch-compare and slow-ALU path of the RISC-V core.
//  Valid/ready handshake on both input and result sides.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of 4 and >= 8
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands/op_sub valid
//  in_ready   out  1      unit can accept an operation
//  a          in   WIDTH  minuend / addend
//  b          in   WIDTH  subtrahend / addend
//  op_sub     in   1      1: a-b (a + ~b + 1); 0: a+b
//  out_valid  out  1      result and flags valid
//  out_ready  in   1      consumer takes result
//  result     out  WIDTH  a-b or a+b, modulo 2^WIDTH
//  carry      out  1      final carry-out (sub: 1 = no borrow, i.e. a >= b unsigned)
//  zero       out  1      flag, see CONFIGURATION
//  lt_u       out  1      flag, see CONFIGURATION
//  lt_s       out  1      flag, see CONFIGURATION
//  ovf        out  1      flag, see CONFIGURATION
// BEHAVIOUR
//  - States: IDLE -> RUN -> DONE -> IDLE. Reset state IDLE; counter, operand regs,
//    carry flop, result, carry, flags and out_valid all reset to 0.
//  - in_ready = (state==IDLE) & ~rst. Accept on rising edge with in_valid & in_ready:
//    latch a, b (b inverted when op_sub), op_sub; carry flop <= op_sub; nibble count <= 0; go RUN.
//  - RUN: each cycle process nibble k = count: {c,s} = a[k]+b'[k]+carry flop;
//    write s into result[4k+3:4k], carry flop <= c, count++. After nibble N-1
//    (N=WIDTH/4) go DONE. out_valid rises exactly N cycles after the accept edge.
//  - in_valid/a/b ignored outside IDLE; operands need be stable only on accept edge.
//  - DONE: out_valid=1; result, carry, flags held stable until out_valid & out_ready
//    sampled; then IDLE (out_valid 0 next cycle). No new accept in the same cycle
//    as result handoff; earliest re-accept is the cycle after returning to IDLE.
//  - result/carry/flags hold last values after handoff until next completion.
//  - Arithmetic: all modulo 2^WIDTH; carry = carry out of bit WIDTH-1.
//  - rst asserted anywhere (incl. mid-RUN): immediately IDLE, outputs 0, partial
//    result discarded; in_ready=1 in the first cycle after rst deasserts.
// CONFIGURATION
//  Macro NSS_CMP_FLAGS_EN:
//  - defined: flags registered on entry to DONE:
//    zero = (result==0); lt_u = op_sub & ~carry;
//    ovf  = sub: a[MSB]!=b[MSB] & result[MSB]!=a[MSB]; add: a[MSB]==b[MSB] & result[MSB]!=a[MSB];
//    lt_s = op_sub & (result[MSB] ^ ovf); lt_u, lt_s = 0 for add.
//  - undefined: zero, lt_u, lt_s, ovf tied to 0; no flag logic synthesised.
// TESTING (WIDTH=32, NSS_CMP_FLAGS_EN defined unless noted)
//  1 sub 5-3 -> out_valid 8 cycles after accept; result 0x00000002, carry 1, zero/lt_u/lt_s/ovf 0.
//  2 sub 3-5 -> result 0xFFFFFFFE, carry 0, lt_u 1, lt_s 1, ovf 0.
//  3 sub 0x7FFFFFFF-0xFFFFFFFF -> result 0x80000000, ovf 1, lt_s 0, lt_u 1.
//  4 add 0xFFFFFFFF+0x00000001 -> result 0, carry 1, zero 1, ovf 0; macro undefined: zero 0.
//  5 out_ready low 5 cycles in DONE -> out_valid/result stable, in_ready 0; handoff then in_ready 1 next cycle.
//  6 rst pulse at RUN cycle 3 -> out_valid 0, result 0, state IDLE; new op 9-9 completes with zero 1.

Source files
------------

// File: rtl/nibble_serial_subtractor_if.sv
// rtl/nibble_serial_subtractor_if.sv - operand/result handshake bundle for nibble_serial_subtractor
interface nibble_serial_subtractor_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             lt_u;
  logic             lt_s;
  logic             ovf;

  modport master (
    output in_valid, a, b, op_sub, out_ready,
    input  in_ready, out_valid, result, carry, zero, lt_u, lt_s, ovf
  );

  modport slave (
    input  in_valid, a, b, op_sub, out_ready,
    output in_ready, out_valid, result, carry, zero, lt_u, lt_s, ovf
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// rtl/nibble_serial_subtractor.sv - nibble-serial WIDTH-bit add/sub unit; compare flags under NSS_CMP_FLAGS_EN
module nibble_serial_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  nibble_serial_subtractor_if.slave  nss
);
  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cy_q;
  logic [WIDTH-5:0] acc_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;

  logic             accept;
  logic             last;
  logic             in_ready_d;
  logic             out_valid_d;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] nib_word;

  // Operands are shifted right each cycle, so the active nibble is always
  // bits [3:0]; the partial sum enters from the top and reaches its final
  // position after the last nibble.
  assign nib_sum  = {1'b0, a_q[3:0]} + {1'b0, b_q[3:0]} + {4'b0000, cy_q};
  assign nib_word = {nib_sum[3:0], acc_q};
  assign last     = (cnt_q == CW'(N - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d     = state_q;
    in_ready_d  = 1'b0;
    out_valid_d = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_d = ~rst;
        if (nss.in_valid && !rst) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        if (nss.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch, per-nibble ripple step and result capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cy_q     <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      cnt_q <= '0;
      a_q   <= nss.a;
      b_q   <= nss.op_sub ? ~nss.b : nss.b;
      cy_q  <= nss.op_sub;
      acc_q <= '0;
    end else if (state_q == RUN) begin
      cnt_q <= cnt_q + CW'(1);
      a_q   <= a_q >> 4;
      b_q   <= b_q >> 4;
      cy_q  <= nib_sum[4];
      acc_q <= nib_word[WIDTH-1:4];
      if (last) begin
        result_q <= nib_word;
        carry_q  <= nib_sum[4];
      end
    end
  end

  assign nss.in_ready  = in_ready_d;
  assign nss.out_valid = out_valid_d;
  assign nss.result    = result_q;
  assign nss.carry     = carry_q;

`ifdef NSS_CMP_FLAGS_EN
  logic op_sub_q;
  logic zero_q, lt_u_q, lt_s_q, ovf_q;
  logic ovf_c;

  // b_q holds the possibly inverted subtrahend, so one sign rule covers both ops:
  // overflow when the effective operands agree in sign and the sum does not.
  assign ovf_c = (a_q[3] == b_q[3]) && (nib_sum[3] != a_q[3]);

  // Compare flags captured together with the final nibble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_sub_q <= 1'b0;
      zero_q   <= 1'b0;
      lt_u_q   <= 1'b0;
      lt_s_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept) begin
      op_sub_q <= nss.op_sub;
    end else if (state_q == RUN && last) begin
      zero_q <= (nib_word == '0);
      lt_u_q <= op_sub_q & ~nib_sum[4];
      lt_s_q <= op_sub_q & (nib_sum[3] ^ ovf_c);
      ovf_q  <= ovf_c;
    end
  end

  assign nss.zero = zero_q;
  assign nss.lt_u = lt_u_q;
  assign nss.lt_s = lt_s_q;
  assign nss.ovf  = ovf_q;
`else
  assign nss.zero = 1'b0;
  assign nss.lt_u = 1'b0;
  assign nss.lt_s = 1'b0;
  assign nss.ovf  = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// tb/tb_nibble_serial_subtractor.sv - randomized self-checking bench for nibble_serial_subtractor
module tb_nibble_serial_subtractor;
  localparam int W   = 32;
  localparam int LAT = W / 4;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -SMAX - 64'sd1;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .nss (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: flags {carry, zero, lt_u, lt_s, ovf} from plain arithmetic
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                output logic [W-1:0] r, output logic [4:0] f);
    longint sa, sb, sd;
    logic c, z, lu, ls, o;
    sa = $signed(a);
    sb = $signed(b);
    if (sub) begin
      r  = a - b;
      c  = (a >= b);
      sd = sa - sb;
      lu = (a < b);
      ls = (sa < sb);
    end else begin
      r  = a + b;
      c  = (({32'b0, a} + {32'b0, b}) > 64'h0000_0000_FFFF_FFFF);
      sd = sa + sb;
      lu = 1'b0;
      ls = 1'b0;
    end
    o = (sd > SMAX) || (sd < SMIN);
    z = (r == '0);
`ifndef NSS_CMP_FLAGS_EN
    z  = 1'b0;
    lu = 1'b0;
    ls = 1'b0;
    o  = 1'b0;
`endif
    f = {c, z, lu, ls, o};
  endfunction

  function automatic logic [4:0] obs_flags();
    return {bus.carry, bus.zero, bus.lt_u, bus.lt_s, bus.ovf};
  endfunction

  // Drives one operation; junk on the input side while busy; stalls out_ready
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input int stall, output int lat, output logic [W-1:0] r,
                        output logic [4:0] f, output logic hold_ok, output logic handoff_ok);
    int guard;
    logic [W-1:0] prev_r;
    guard   = 0;
    hold_ok = 1'b1;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    prev_r       = bus.result;
    bus.a        = a;
    bus.b        = b;
    bus.op_sub   = sub;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      if (bus.result !== prev_r || bus.in_ready) hold_ok = 1'b0;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.a        = $urandom;
      bus.b        = $urandom;
      bus.op_sub   = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    r = bus.result;
    f = obs_flags();
    repeat (stall) begin
      @(posedge clk); #1;
      if (bus.result !== r || obs_flags() !== f || !bus.out_valid || bus.in_ready) hold_ok = 1'b0;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    handoff_ok = !bus.out_valid && bus.in_ready && (bus.result === r) && (obs_flags() === f);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 0 0", bus.in_ready, bus.out_valid);
    end
    checks++;
    if (bus.result !== '0 || obs_flags() !== 5'b0) begin
      errors++;
      $display("FAIL reset_out: result=%h flags=%b want 0", bus.result, obs_flags());
    end
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b want 1", bus.in_ready);
    end
  endtask

  task automatic test_vectors();
    logic [W-1:0] va [4];
    logic [W-1:0] vb [4];
    logic         vs [4];
    logic [W-1:0] r, er;
    logic [4:0]   f, ef;
    logic         hok, hdo;
    int           lat;
    va[0] = 32'd5;         vb[0] = 32'd3;         vs[0] = 1'b1;
    va[1] = 32'd3;         vb[1] = 32'd5;         vs[1] = 1'b1;
    va[2] = 32'h7FFFFFFF;  vb[2] = 32'hFFFFFFFF;  vs[2] = 1'b1;
    va[3] = 32'hFFFFFFFF;  vb[3] = 32'h00000001;  vs[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], vs[i], 0, lat, r, f, hok, hdo);
      model(va[i], vb[i], vs[i], er, ef);
      checks++;
      if (lat !== LAT) begin errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, LAT); end
      checks++;
      if (r !== er) begin errors++; $display("FAIL vec%0d_result: got %h want %h", i, r, er); end
      checks++;
      if (f !== ef) begin errors++; $display("FAIL vec%0d_flags: got %b want %b", i, f, ef); end
      checks++;
      if (hdo !== 1'b1) begin errors++; $display("FAIL vec%0d_handoff: got %b want 1", i, hdo); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r, er;
    logic [4:0]   f, ef;
    logic         hok, hdo;
    int           lat;
    run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5, lat, r, f, hok, hdo);
    model(32'h1234_5678, 32'h0FED_CBA9, 1'b1, er, ef);
    checks++;
    if (r !== er || f !== ef) begin
      errors++;
      $display("FAIL bp_value: got %h/%b want %h/%b", r, f, er, ef);
    end
    checks++;
    if (hok !== 1'b1) begin errors++; $display("FAIL bp_hold: stable=%b want 1", hok); end
    checks++;
    if (hdo !== 1'b1) begin errors++; $display("FAIL bp_handoff: got %b want 1", hdo); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er;
    logic [4:0]   f, ef;
    logic         hok, hdo;
    int           lat;
    run_op(32'd100, 32'd1, 1'b1, 2, lat, r, f, hok, hdo);
    bus.a = 32'hDEAD_0000; bus.b = 32'h0000_BEEF; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept: in_ready=%b want 0", bus.in_ready); end
    lat = 0;
    while (!bus.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    model(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, er, ef);
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL b2b_latency: got %0d want %0d", lat, LAT); end
    checks++;
    if (bus.result !== er || obs_flags() !== ef) begin
      errors++;
      $display("FAIL b2b_value: got %h/%b want %h/%b", bus.result, obs_flags(), er, ef);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] r, er;
    logic [4:0]   f, ef;
    logic         hok, hdo;
    int           lat;
    run_op(32'd5, 32'd3, 1'b1, 0, lat, r, f, hok, hdo);
    bus.a = 32'h8888_8888; bus.b = 32'h1111_1111; bus.op_sub = 1'b0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.result !== '0 || bus.carry !== 1'b0) begin
      errors++;
      $display("FAIL rstrun_out: out_valid=%b result=%h carry=%b want 0", bus.out_valid, bus.result, bus.carry);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstrun_ready: in_ready=%b want 1", bus.in_ready); end
    run_op(32'd9, 32'd9, 1'b1, 1, lat, r, f, hok, hdo);
    model(32'd9, 32'd9, 1'b1, er, ef);
    checks++;
    if (lat !== LAT || r !== er || f !== ef) begin
      errors++;
      $display("FAIL rstrun_op: lat=%0d result=%h flags=%b want %0d %h %b", lat, r, f, LAT, er, ef);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er;
    logic         s, hok, hdo;
    logic [4:0]   f, ef;
    int           lat;
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      case (i % 4)
        1: b = a;
        2: b = a ^ 32'h8000_0000;
        default: ;
      endcase
      s = 1'($urandom_range(0, 1));
      run_op(a, b, s, $urandom_range(0, 3), lat, r, f, hok, hdo);
      model(a, b, s, er, ef);
      checks++;
      if (lat !== LAT || hok !== 1'b1 || hdo !== 1'b1) begin
        errors++;
        $display("FAIL rnd%0d_timing: lat=%0d hold=%b handoff=%b want %0d 1 1", i, lat, hok, hdo, LAT);
      end
      checks++;
      if (r !== er || f !== ef) begin
        errors++;
        $display("FAIL rnd%0d_value: a=%h b=%h sub=%b got %h/%b want %h/%b", i, a, b, s, r, f, er, ef);
      end
    end
  endtask

  initial begin
    clk           = 1'b0;
    rst           = 1'b1;
    errors        = 0;
    checks        = 0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.op_sub    = 1'b0;
    bus.out_ready = 1'b0;
    test_reset();
    test_vectors();
    test_backpressure();
    test_back_to_back();
    test_reset_midrun();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
